// File: rtl/axil_demux_1to2.sv
// AXI4-Lite 1-to-2 address router: the top address bit selects the target.
// Write and read paths are independent and each has one transaction in flight.
// Address and write data are registered toward the targets; B and R responses
// are routed back combinationally from the selected target only.
module axil_demux_1to2 #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 32
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    // upstream write address / data / response
    input  logic [ADDR_W-1:0]       s_AWADDR,
    input  logic                    s_AWVALID,
    output logic                    s_AWREADY,
    input  logic [DATA_W-1:0]       s_WDATA,
    input  logic [DATA_W/8-1:0]     s_WSTRB,
    input  logic                    s_WVALID,
    output logic                    s_WREADY,
    output logic [1:0]              s_BRESP,
    output logic                    s_BVALID,
    input  logic                    s_BREADY,
    // upstream read address / data
    input  logic [ADDR_W-1:0]       s_ARADDR,
    input  logic                    s_ARVALID,
    output logic                    s_ARREADY,
    output logic [DATA_W-1:0]       s_RDATA,
    output logic [1:0]              s_RRESP,
    output logic                    s_RVALID,
    input  logic                    s_RREADY,
    // downstream, address/data broadcast, handshakes per target
    output logic [ADDR_W-2:0]       m_AWADDR,
    output logic [1:0]              m_AWVALID,
    input  logic [1:0]              m_AWREADY,
    output logic [DATA_W-1:0]       m_WDATA,
    output logic [DATA_W/8-1:0]     m_WSTRB,
    output logic [1:0]              m_WVALID,
    input  logic [1:0]              m_WREADY,
    input  logic [3:0]              m_BRESP,
    input  logic [1:0]              m_BVALID,
    output logic [1:0]              m_BREADY,
    output logic [ADDR_W-2:0]       m_ARADDR,
    output logic [1:0]              m_ARVALID,
    input  logic [1:0]              m_ARREADY,
    input  logic [2*DATA_W-1:0]     m_RDATA,
    input  logic [3:0]              m_RRESP,
    input  logic [1:0]              m_RVALID,
    output logic [1:0]              m_RREADY
);

    localparam int unsigned TADDR_W = ADDR_W - 1;
    localparam int unsigned STRB_W  = DATA_W / 8;

    typedef enum logic [1:0] {W_IDLE, W_FWD, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_FWD, R_RESP} r_state_e;

    w_state_e            w_state_q, w_state_d;
    r_state_e            r_state_q, r_state_d;
    logic                wsel_q, wsel_d, rsel_q, rsel_d;
    logic                aw_done_q, aw_done_d;
    logic                w_held_q, w_held_d;
    logic                w_done_q, w_done_d;
    logic [TADDR_W-1:0]  awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;

    assign m_AWADDR = awaddr_q;
    assign m_ARADDR = araddr_q;
    assign m_WDATA  = wdata_q;
    assign m_WSTRB  = wstrb_q;

    // State and latch registers for both paths
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            wsel_q    <= 1'b0;
            rsel_q    <= 1'b0;
            aw_done_q <= 1'b0;
            w_held_q  <= 1'b0;
            w_done_q  <= 1'b0;
            awaddr_q  <= '0;
            araddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            wsel_q    <= wsel_d;
            rsel_q    <= rsel_d;
            aw_done_q <= aw_done_d;
            w_held_q  <= w_held_d;
            w_done_q  <= w_done_d;
            awaddr_q  <= awaddr_d;
            araddr_q  <= araddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
        end
    end

    // Write path next state, handshakes and B routing
    always_comb begin
        w_state_d = w_state_q;
        wsel_d    = wsel_q;
        aw_done_d = aw_done_q;
        w_held_d  = w_held_q;
        w_done_d  = w_done_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        s_AWREADY = 1'b0;
        s_WREADY  = 1'b0;
        s_BVALID  = 1'b0;
        s_BRESP   = 2'b00;
        m_AWVALID = 2'b00;
        m_WVALID  = 2'b00;
        m_BREADY  = 2'b00;
        unique case (w_state_q)
            W_IDLE: begin
                s_AWREADY = 1'b1;
                if (s_AWVALID) begin
                    awaddr_d  = s_AWADDR[TADDR_W-1:0];
                    wsel_d    = s_AWADDR[ADDR_W-1];
                    aw_done_d = 1'b0;
                    w_held_d  = 1'b0;
                    w_done_d  = 1'b0;
                    w_state_d = W_FWD;
                end
            end
            W_FWD: begin
                m_AWVALID[wsel_q] = ~aw_done_q;
                if (!aw_done_q && m_AWREADY[wsel_q]) aw_done_d = 1'b1;
                s_WREADY = ~w_held_q;
                if (!w_held_q && s_WVALID) begin
                    wdata_d  = s_WDATA;
                    wstrb_d  = s_WSTRB;
                    w_held_d = 1'b1;
                end
                m_WVALID[wsel_q] = w_held_q & ~w_done_q;
                if (w_held_q && !w_done_q && m_WREADY[wsel_q]) w_done_d = 1'b1;
                if (aw_done_d && w_done_d) w_state_d = W_RESP;
            end
            W_RESP: begin
                s_BVALID         = m_BVALID[wsel_q];
                s_BRESP          = wsel_q ? m_BRESP[3:2] : m_BRESP[1:0];
                m_BREADY[wsel_q] = s_BREADY;
                if (m_BVALID[wsel_q] && s_BREADY) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
        // No handshake is offered while reset is held
        if (!ARESETn) begin
            s_AWREADY = 1'b0;
            s_WREADY  = 1'b0;
            s_BVALID  = 1'b0;
            s_BRESP   = 2'b00;
            m_AWVALID = 2'b00;
            m_WVALID  = 2'b00;
            m_BREADY  = 2'b00;
        end
    end

    // Read path next state, handshakes and R routing
    always_comb begin
        r_state_d = r_state_q;
        rsel_d    = rsel_q;
        araddr_d  = araddr_q;
        s_ARREADY = 1'b0;
        s_RVALID  = 1'b0;
        s_RDATA   = '0;
        s_RRESP   = 2'b00;
        m_ARVALID = 2'b00;
        m_RREADY  = 2'b00;
        unique case (r_state_q)
            R_IDLE: begin
                s_ARREADY = 1'b1;
                if (s_ARVALID) begin
                    araddr_d  = s_ARADDR[TADDR_W-1:0];
                    rsel_d    = s_ARADDR[ADDR_W-1];
                    r_state_d = R_FWD;
                end
            end
            R_FWD: begin
                m_ARVALID[rsel_q] = 1'b1;
                if (m_ARREADY[rsel_q]) r_state_d = R_RESP;
            end
            R_RESP: begin
                s_RVALID         = m_RVALID[rsel_q];
                s_RDATA          = rsel_q ? m_RDATA[2*DATA_W-1:DATA_W] : m_RDATA[DATA_W-1:0];
                s_RRESP          = rsel_q ? m_RRESP[3:2] : m_RRESP[1:0];
                m_RREADY[rsel_q] = s_RREADY;
                if (m_RVALID[rsel_q] && s_RREADY) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
        // No handshake is offered while reset is held
        if (!ARESETn) begin
            s_ARREADY = 1'b0;
            s_RVALID  = 1'b0;
            s_RDATA   = '0;
            s_RRESP   = 2'b00;
            m_ARVALID = 2'b00;
            m_RREADY  = 2'b00;
        end
    end

endmodule

// File: tb/tb_axil_demux_1to2.sv
// Bench for axil_demux_1to2: table of write/read transactions with a response
// scoreboard, plus hand sequences for overlap and mid-transaction reset.
module tb_axil_demux_1to2;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [10:0] s_AWADDR;  logic s_AWVALID; logic s_AWREADY;
    logic [31:0] s_WDATA;   logic [3:0] s_WSTRB; logic s_WVALID; logic s_WREADY;
    logic [1:0]  s_BRESP;   logic s_BVALID;  logic s_BREADY;
    logic [10:0] s_ARADDR;  logic s_ARVALID; logic s_ARREADY;
    logic [31:0] s_RDATA;   logic [1:0] s_RRESP; logic s_RVALID; logic s_RREADY;
    logic [9:0]  m_AWADDR;  logic [1:0] m_AWVALID; logic [1:0] m_AWREADY;
    logic [31:0] m_WDATA;   logic [3:0] m_WSTRB;
    logic [1:0]  m_WVALID;  logic [1:0] m_WREADY;
    logic [3:0]  m_BRESP;   logic [1:0] m_BVALID;  logic [1:0] m_BREADY;
    logic [9:0]  m_ARADDR;  logic [1:0] m_ARVALID; logic [1:0] m_ARREADY;
    logic [63:0] m_RDATA;   logic [3:0] m_RRESP;
    logic [1:0]  m_RVALID;  logic [1:0] m_RREADY;

    axil_demux_1to2 dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .s_AWADDR(s_AWADDR), .s_AWVALID(s_AWVALID), .s_AWREADY(s_AWREADY),
        .s_WDATA(s_WDATA), .s_WSTRB(s_WSTRB), .s_WVALID(s_WVALID), .s_WREADY(s_WREADY),
        .s_BRESP(s_BRESP), .s_BVALID(s_BVALID), .s_BREADY(s_BREADY),
        .s_ARADDR(s_ARADDR), .s_ARVALID(s_ARVALID), .s_ARREADY(s_ARREADY),
        .s_RDATA(s_RDATA), .s_RRESP(s_RRESP), .s_RVALID(s_RVALID), .s_RREADY(s_RREADY),
        .m_AWADDR(m_AWADDR), .m_AWVALID(m_AWVALID), .m_AWREADY(m_AWREADY),
        .m_WDATA(m_WDATA), .m_WSTRB(m_WSTRB), .m_WVALID(m_WVALID), .m_WREADY(m_WREADY),
        .m_BRESP(m_BRESP), .m_BVALID(m_BVALID), .m_BREADY(m_BREADY),
        .m_ARADDR(m_ARADDR), .m_ARVALID(m_ARVALID), .m_ARREADY(m_ARREADY),
        .m_RDATA(m_RDATA), .m_RRESP(m_RRESP), .m_RVALID(m_RVALID), .m_RREADY(m_RREADY)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        bit          wr;
        logic [10:0] addr;
        logic [31:0] data;   // write data, or target read data
        logic [3:0]  strb;
        logic [1:0]  resp;   // target response code
        int          stall;  // cycles the target withholds address ready
        bit          w_early;
        bit          stray;  // unselected target drives a bogus response
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } sb_t;

    vec_t vt[7];
    sb_t  sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        s_AWVALID = 1'b0; s_WVALID = 1'b0; s_BREADY = 1'b0;
        s_ARVALID = 1'b0; s_RREADY = 1'b0;
        m_AWREADY = 2'b00; m_WREADY = 2'b00; m_BVALID = 2'b00; m_BRESP = 4'h0;
        m_ARREADY = 2'b00; m_RVALID = 2'b00; m_RDATA = 64'h0; m_RRESP = 4'h0;
    endtask

    task automatic sb_pop(input string nm, input logic [31:0] d, input logic [1:0] r, input bit use_d);
        sb_t e;
        if (sb.size() == 0) begin
            chk({nm, "_sb_empty"}, 64'(1), 64'(0));
        end else begin
            e = sb.pop_front();
            chk({nm, "_resp"}, 64'(r), 64'(e.resp));
            if (use_d) chk({nm, "_data"}, 64'(d), 64'(e.data));
        end
    endtask

    task automatic do_write(input vec_t v);
        logic sel; logic [1:0] oh; bit aw_ok, w_hold, w_ok, resp_ph, done; sb_t e;
        sel = v.addr[10]; oh = sel ? 2'b10 : 2'b01;
        s_AWADDR = v.addr; s_WDATA = v.data; s_WSTRB = v.strb; s_BREADY = 1'b1;
        if (v.w_early) begin
            s_WVALID = 1'b1;
            repeat (2) begin
                #1 chk("wready_pre_aw", 64'(s_WREADY), 64'(0));
                @(posedge ACLK); #1;
            end
        end
        s_AWVALID = 1'b1; s_WVALID = 1'b1;
        #1;
        chk("awready_idle", 64'(s_AWREADY), 64'(1));
        chk("wready_idle", 64'(s_WREADY), 64'(0));
        @(posedge ACLK); #1;
        s_AWVALID = 1'b0;
        aw_ok = 0; w_hold = 0; w_ok = 0; resp_ph = 0; done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            m_AWREADY = (c >= v.stall) ? 2'b11 : 2'b00;
            m_WREADY  = 2'b11;
            m_BVALID  = v.stray ? ~oh : 2'b00;
            m_BRESP   = sel ? {v.resp, ~v.resp} : {~v.resp, v.resp};
            if (resp_ph) begin
                m_BVALID = m_BVALID | oh;
                e.data = 32'h0; e.resp = v.resp; sb.push_back(e);
            end
            #1;
            if (!resp_ph) begin
                chk("m_awvalid", 64'(m_AWVALID), 64'(aw_ok ? 2'b00 : oh));
                chk("m_awaddr", 64'(m_AWADDR), 64'(v.addr[9:0]));
                chk("s_wready", 64'(s_WREADY), 64'(!w_hold));
                chk("m_wvalid", 64'(m_WVALID), 64'((w_hold && !w_ok) ? oh : 2'b00));
                if (w_hold) begin
                    chk("m_wdata", 64'(m_WDATA), 64'(v.data));
                    chk("m_wstrb", 64'(m_WSTRB), 64'(v.strb));
                end
                chk("s_bvalid_early", 64'(s_BVALID), 64'(0));
            end else begin
                chk("s_bvalid", 64'(s_BVALID), 64'(1));
                chk("m_bready", 64'(m_BREADY), 64'(oh));
                if (s_BVALID) sb_pop("b", 32'h0, s_BRESP, 1'b0);
                else void'(sb.pop_back());
                done = 1;
            end
            if (!resp_ph) begin
                if (!aw_ok && m_AWREADY[sel]) aw_ok = 1;
                if (w_hold && !w_ok) w_ok = 1;
                if (!w_hold && s_WVALID) w_hold = 1;
                if (aw_ok && w_ok) resp_ph = 1;
            end
            @(posedge ACLK); #1;
            if (w_hold) s_WVALID = 1'b0;
        end
        if (!done) chk("write_timeout", 64'(0), 64'(1));
        idle_inputs();
        #1 chk("awready_after_b", 64'(s_AWREADY), 64'(1));
    endtask

    task automatic do_read(input vec_t v);
        logic sel; logic [1:0] oh; bit ar_ok, done; sb_t e;
        sel = v.addr[10]; oh = sel ? 2'b10 : 2'b01;
        s_ARADDR = v.addr; s_RREADY = 1'b1; s_ARVALID = 1'b1;
        #1 chk("arready_idle", 64'(s_ARREADY), 64'(1));
        @(posedge ACLK); #1;
        s_ARVALID = 1'b0;
        ar_ok = 0; done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            m_ARREADY = (c >= v.stall) ? 2'b11 : 2'b00;
            m_RVALID  = v.stray ? ~oh : 2'b00;
            m_RDATA   = sel ? {v.data, ~v.data} : {~v.data, v.data};
            m_RRESP   = sel ? {v.resp, ~v.resp} : {~v.resp, v.resp};
            if (ar_ok) begin
                m_RVALID = m_RVALID | oh;
                e.data = v.data; e.resp = v.resp; sb.push_back(e);
            end
            #1;
            chk("s_arready_busy", 64'(s_ARREADY), 64'(0));
            if (!ar_ok) begin
                chk("m_arvalid", 64'(m_ARVALID), 64'(oh));
                chk("m_araddr", 64'(m_ARADDR), 64'(v.addr[9:0]));
                chk("s_rvalid_early", 64'(s_RVALID), 64'(0));
                if (m_ARREADY[sel]) ar_ok = 1;
            end else begin
                chk("s_rvalid", 64'(s_RVALID), 64'(1));
                chk("m_rready", 64'(m_RREADY), 64'(oh));
                if (s_RVALID) sb_pop("r", s_RDATA, s_RRESP, 1'b1);
                else void'(sb.pop_back());
                done = 1;
            end
            @(posedge ACLK); #1;
        end
        if (!done) chk("read_timeout", 64'(0), 64'(1));
        idle_inputs();
        #1 chk("arready_after_r", 64'(s_ARREADY), 64'(1));
    endtask

    initial begin
        //            wr  addr     data          strb  resp  stall early stray
        vt[0] = '{1'b1, 11'h405, 32'hDEADBEEF, 4'hF, 2'b00, 0, 1'b0, 1'b0};
        vt[1] = '{1'b0, 11'h003, 32'h12345678, 4'h0, 2'b00, 0, 1'b0, 1'b0};
        vt[2] = '{1'b1, 11'h123, 32'hA5A50F0F, 4'h3, 2'b10, 0, 1'b1, 1'b0};
        vt[3] = '{1'b1, 11'h7FE, 32'h01234567, 4'hC, 2'b01, 5, 1'b0, 1'b1};
        vt[4] = '{1'b0, 11'h7FF, 32'hC0FFEE11, 4'h0, 2'b11, 3, 1'b0, 1'b1};
        vt[5] = '{1'b1, 11'h000, 32'h55AA55AA, 4'h9, 2'b11, 1, 1'b0, 1'b1};
        vt[6] = '{1'b0, 11'h400, 32'h87654321, 4'h0, 2'b10, 0, 1'b0, 1'b0};

        ARESETn = 1'b0;
        s_AWADDR = '0; s_WDATA = '0; s_WSTRB = '0; s_ARADDR = '0;
        idle_inputs();
        repeat (2) @(posedge ACLK);
        #1;
        chk("rst_handshakes", 64'({s_AWREADY, s_WREADY, s_BVALID, s_ARREADY, s_RVALID,
                                   m_AWVALID, m_WVALID, m_BREADY, m_ARVALID, m_RREADY}), 64'(0));
        chk("rst_addrs", 64'({m_AWADDR, m_ARADDR}), 64'(0));
        chk("rst_wdata", 64'({m_WDATA, m_WSTRB}), 64'(0));
        ARESETn = 1'b1;
        #1;
        chk("rel_awready", 64'(s_AWREADY), 64'(1));
        chk("rel_arready", 64'(s_ARREADY), 64'(1));
        @(posedge ACLK); #1;

        for (int i = 0; i < 7; i++) begin
            if (vt[i].wr) do_write(vt[i]);
            else          do_read(vt[i]);
            @(posedge ACLK); #1;
        end

        // Overlapping read to target 1 and write to target 0
        s_AWADDR = 11'h000; s_WDATA = 32'h0BADCAFE; s_WSTRB = 4'hF;
        s_AWVALID = 1'b1; s_WVALID = 1'b1; s_BREADY = 1'b1;
        s_ARADDR = 11'h7FF; s_ARVALID = 1'b1; s_RREADY = 1'b1;
        #1;
        chk("ov_ready_both", 64'({s_AWREADY, s_ARREADY}), 64'(2'b11));
        @(posedge ACLK); #1;
        s_AWVALID = 1'b0; s_ARVALID = 1'b0;
        m_AWREADY = 2'b11; m_ARREADY = 2'b11; m_WREADY = 2'b11;
        #1;
        chk("ov_awvalid", 64'(m_AWVALID), 64'(2'b01));
        chk("ov_arvalid", 64'(m_ARVALID), 64'(2'b10));
        chk("ov_araddr", 64'(m_ARADDR), 64'(10'h3FF));
        chk("ov_wready", 64'(s_WREADY), 64'(1));
        @(posedge ACLK); #1;
        s_WVALID = 1'b0;
        m_RVALID = 2'b10; m_RDATA = {32'h13572468, 32'hFFFF0000}; m_RRESP = 4'b0110;
        #1;
        chk("ov_wvalid", 64'(m_WVALID), 64'(2'b01));
        chk("ov_rvalid", 64'(s_RVALID), 64'(1));
        chk("ov_rdata", 64'({s_RDATA, s_RRESP}), 64'({32'h13572468, 2'b01}));
        chk("ov_rready", 64'(m_RREADY), 64'(2'b10));
        @(posedge ACLK); #1;
        m_RVALID = 2'b00; m_BVALID = 2'b01; m_BRESP = 4'b0110;
        #1;
        chk("ov_arready_back", 64'(s_ARREADY), 64'(1));
        chk("ov_bresp", 64'({s_BVALID, s_BRESP}), 64'({1'b1, 2'b10}));
        chk("ov_bready", 64'(m_BREADY), 64'(2'b01));
        @(posedge ACLK); #1;
        idle_inputs();
        #1 chk("ov_awready_back", 64'(s_AWREADY), 64'(1));

        // Reset in the middle of a write
        @(posedge ACLK); #1;
        s_AWADDR = 11'h412; s_WDATA = 32'hCAFEF00D; s_WSTRB = 4'h6;
        s_AWVALID = 1'b1; s_WVALID = 1'b1;
        @(posedge ACLK); #1;
        s_AWVALID = 1'b0;
        @(posedge ACLK); #1;
        s_WVALID = 1'b0;
        chk("mr_held_wvalid", 64'(m_WVALID), 64'(2'b10));
        ARESETn = 1'b0;
        #1 chk("mr_gate", 64'({s_AWREADY, s_ARREADY, m_AWVALID, m_WVALID}), 64'(0));
        @(posedge ACLK); #1;
        chk("mr_handshakes", 64'({s_AWREADY, s_WREADY, s_BVALID, s_ARREADY, s_RVALID,
                                  m_AWVALID, m_WVALID, m_BREADY, m_ARVALID, m_RREADY}), 64'(0));
        chk("mr_addrs", 64'({m_AWADDR, m_ARADDR}), 64'(0));
        chk("mr_wdata", 64'({m_WDATA, m_WSTRB}), 64'(0));
        ARESETn = 1'b1;
        #1 chk("mr_readys", 64'({s_AWREADY, s_ARREADY}), 64'(2'b11));
        @(posedge ACLK); #1;
        do_write(vt[3]);
        chk("sb_drained", 64'(sb.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
